hdlc_line_monitor: RTL and testbench
====================================

// Module: hdlc_line_monitor
// PURPOSE
// Synthesizable multi-channel HDLC line monitor; the on-chip counterpart of the bench protocol checks.
// Watches N_CH serial HDLC bit streams (Rx or Tx lines) and classifies flag, abort, idle and
// zero-stuffed frame traffic per channel.
// Keeps saturating event counters, sticky error bits and a masked interrupt, readable over the register bus.
// PARAMETERS
// N_CH           2    number of monitored serial channels (1..8)
// CNT_W          16   width of each event counter and of DataIn/DataOut
// IDLE_LEN       15   consecutive ones that declare line idle (>= 8)
// MIN_FRAME_BITS 32   smallest legal destuffed payload (bits, incl. FCS)
// BITCNT_W       12   width of per-channel payload bit counter (saturating)
// PORTS
// Clk          in   1             system clock
// Rst          in   1             synchronous reset, active-high
// LineIn       in   N_CH          serial bit per channel
// LineVld      in   N_CH          bit strobe; LineIn[c] sampled only when LineVld[c]=1
// Address      in   $clog2(N_CH)+3  {channel, reg[2:0]}
// ReadEnable   in   1             register read request
// WriteEnable  in   1             register write request
// DataIn       in   CNT_W         write data
// DataOut      out  CNT_W         read data, valid with DataOutVld
// DataOutVld   out  1             one-cycle pulse, one cycle after ReadEnable
// FlagDetect   out  N_CH          one-cycle pulse per detected flag
// AbortDetect  out  N_CH          one-cycle pulse per detected abort
// FrameGood    out  N_CH          one-cycle pulse per correctly closed frame
// Irq          out  1             OR over channels of (sticky & mask)
// BEHAVIOUR
// - Reset: all outputs 0; counters, sticky, mask 0; shift reg S=8'hFF; ones-run 0; state IDLE.
// - Per strobed bit b: S<={S[6:0],b}; ones-run = b ? sat_inc(ones,IDLE_LEN) : 0. No strobe -> no change.
// - Flag: S==8'b0111_1110 after the shift -> FlagDetect pulse next cycle (latency 1 from strobe).
// - Abort: ones-run reaches exactly 7 -> AbortDetect pulse; aborts counter +1.
// - Idle: ones-run reaches IDLE_LEN -> idle counter +1, state IDLE (once per run).
// - States: IDLE, OPEN (flag seen), FRAME (payload bits after flag).
//   any --flag--> OPEN (evaluate frame first if FRAME); OPEN --payload>=8 bits--> FRAME;
//   OPEN/FRAME --abort--> IDLE (FRAME: sticky abort set); IDLE ignores data bits.
// - Destuffing in OPEN/FRAME: b==0 with prior ones-run==5 is a stuffed zero, not counted; all other bits
//   increment bitcnt (saturates at all-ones). bitcnt clears on every flag.
// - At a flag: payload = bitcnt-7 (closing flag's first 7 bits were counted).
//   payload==0: inter-frame fill, nothing counted. payload%8!=0: align counter +1, sticky align.
//   0<payload<MIN_FRAME_BITS (byte-aligned): runt counter +1, sticky runt. else: good counter +1, FrameGood.
//   Align error takes priority over runt; bitcnt saturated -> align error.
// - Counters saturate at all-ones, never wrap.
// - Registers per channel: 0 flags, 1 aborts, 2 good frames, 3 align errs, 4 runts, 5 idle entries,
//   6 status {.., sticky abort[4], runt[3], align[2], state[1:0]}, 7 irq mask (bits 4:2, RW).
// - Read: DataOut/DataOutVld one cycle after ReadEnable; value sampled at request cycle (pre-increment);
//   unused channel index or bits read 0; DataOut=0 when DataOutVld=0.
// - Write reg 6: DataIn[0]=1 clears channel counters, DataIn[1]=1 clears sticky bits; reg 7 loads mask;
//   regs 0-5 read-only (write ignored). Clear and increment same cycle -> clear wins (result 0).
// - ReadEnable and WriteEnable same cycle: write performed, read returns pre-write value.
// - Irq registered: asserts one cycle after sticky/mask update; deasserts one cycle after clear.
// - Rst mid-frame: all state returns to reset values next cycle; partial frame discarded uncounted.
// STRUCTURE
// - hdlc_mon_pkg: state enum {IDLE,OPEN,FRAME}, register index constants, FLAG_PAT=8'h7E, sticky bit positions.
// - Sub-module hdlc_mon_chan: shift reg, ones-run, FSM, bitcnt, counters, sticky, mask;
//   generated N_CH times. Top: address decode, read mux/register, Irq OR.
// TESTING
// - Idle ones x20 on ch0 -> no FlagDetect, idle cnt=1, state IDLE; second idle without 0 -> still 1.
// - Flag, 32 payload bits 0xA5A5_0F0F, flag -> FlagDetect x2, FrameGood x1, reg2=1, reg3=reg4=0.
// - Payload 0x1F (5 ones -> stuffed 0 inserted) x4 bytes -> good frame; omitting stuffing -> abort counted.
// - Flag, 13 payload bits, flag -> align cnt=1, status[2]=1; mask=4 -> Irq=1; write reg6=2 -> Irq=0.
// - Flag, 16 bits, flag -> runt=1; flag, 8 bits, 0111_1111 -> abort=1, sticky abort, state IDLE.
// - Read reg0 same cycle as flag increment -> old value; write reg6=1 with event -> 0; Rst mid-frame -> all 0.

Source files
------------

// File: rtl/hdlc_mon_pkg.sv
// Shared types and constants for the HDLC line monitor.
package hdlc_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_FRAME = 2'd2
  } mon_state_t;

  // Per-channel register map (low three address bits)
  localparam logic [2:0] REG_FLAGS  = 3'd0;
  localparam logic [2:0] REG_ABORTS = 3'd1;
  localparam logic [2:0] REG_GOOD   = 3'd2;
  localparam logic [2:0] REG_ALIGN  = 3'd3;
  localparam logic [2:0] REG_RUNT   = 3'd4;
  localparam logic [2:0] REG_IDLE   = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;
  localparam logic [2:0] REG_MASK   = 3'd7;

  localparam int N_CNT = 6;

  localparam logic [7:0] FLAG_PAT = 8'h7E;

  // Sticky bit positions inside the status / mask registers
  localparam int STK_ALIGN = 2;
  localparam int STK_RUNT  = 3;
  localparam int STK_ABORT = 4;

endpackage

// File: rtl/hdlc_mon_chan.sv
// One monitored HDLC line: flag/abort/idle detection, destuffed bit count,
// frame classification, event counters, sticky errors and irq mask.
//
//   state    | meaning
//   ST_IDLE  | line idle or aborted, data bits ignored
//   ST_OPEN  | flag seen, fewer than 8 bits counted since it
//   ST_FRAME | payload in progress, next flag closes the frame
module hdlc_mon_chan
  import hdlc_mon_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int IDLE_LEN       = 15,
  parameter int MIN_FRAME_BITS = 32,
  parameter int BITCNT_W       = 12
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             line_bit,
  input  logic             line_vld,
  input  logic             wr_en,
  input  logic [2:0]       reg_idx,
  input  logic [4:0]       wr_data,
  output logic [CNT_W-1:0] rd_data,
  output logic             flag_pulse,
  output logic             abort_pulse,
  output logic             good_pulse,
  output logic             irq_req
);

  localparam int ONES_W = $clog2(IDLE_LEN + 1);

  // Only the last seven line bits are kept; the eighth comes from the strobe.
  logic [6:0]          hist_q, hist_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d, payload;
  mon_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q [N_CNT];
  logic [4:2]          sticky_q, mask_q;
  logic [N_CNT-1:0]    inc;
  logic stuffed, ev_flag, ev_abort, ev_frame_abort, ev_idle, ev_good, ev_align, ev_runt;
  logic clr_cnt, clr_stk, ld_mask;

  // Next-state, destuffing and frame classification for one strobed bit
  always_comb begin
    hist_d         = hist_q;
    ones_d         = ones_q;
    bitcnt_d       = bitcnt_q;
    state_d        = state_q;
    stuffed        = 1'b0;
    ev_flag        = 1'b0;
    ev_abort       = 1'b0;
    ev_frame_abort = 1'b0;
    ev_idle        = 1'b0;
    ev_good        = 1'b0;
    ev_align       = 1'b0;
    ev_runt        = 1'b0;
    payload        = bitcnt_q - BITCNT_W'(7);
    if (line_vld) begin
      hist_d   = {hist_q[5:0], line_bit};
      ones_d   = !line_bit ? '0 : (ones_q == ONES_W'(IDLE_LEN)) ? ones_q : ones_q + 1'b1;
      stuffed  = !line_bit && (ones_q == ONES_W'(5));
      ev_abort = line_bit && (ones_q == ONES_W'(6));
      ev_idle  = line_bit && (ones_q == ONES_W'(IDLE_LEN - 1));
      ev_flag  = ({hist_q, line_bit} == FLAG_PAT);
      if (state_q != ST_IDLE && !stuffed && !(&bitcnt_q))
        bitcnt_d = bitcnt_q + 1'b1;
      if (ev_flag) begin
        bitcnt_d = '0;
        state_d  = ST_OPEN;
        if (state_q == ST_FRAME) begin
          if ((&bitcnt_q) || (payload[2:0] != 3'd0))
            ev_align = 1'b1;
          else if (payload != '0 && payload < BITCNT_W'(MIN_FRAME_BITS))
            ev_runt = 1'b1;
          else if (payload != '0)
            ev_good = 1'b1;
        end
      end else if (ev_abort || ev_idle) begin
        ev_frame_abort = ev_abort && (state_q == ST_FRAME);
        state_d        = ST_IDLE;
      end else if (state_q == ST_OPEN && bitcnt_d >= BITCNT_W'(8)) begin
        state_d = ST_FRAME;
      end
    end
  end

  // Line tracking registers and event pulses
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hist_q      <= 7'h7F;
      ones_q      <= '0;
      bitcnt_q    <= '0;
      state_q     <= ST_IDLE;
      flag_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
      good_pulse  <= 1'b0;
    end else begin
      hist_q      <= hist_d;
      ones_q      <= ones_d;
      bitcnt_q    <= bitcnt_d;
      state_q     <= state_d;
      flag_pulse  <= ev_flag;
      abort_pulse <= ev_abort;
      good_pulse  <= ev_good;
    end
  end

  assign clr_cnt = wr_en && (reg_idx == REG_STATUS) && wr_data[0];
  assign clr_stk = wr_en && (reg_idx == REG_STATUS) && wr_data[1];
  assign ld_mask = wr_en && (reg_idx == REG_MASK);

  // Ordered to match register indices 5..0
  assign inc = {ev_idle, ev_runt, ev_align, ev_good, ev_abort, ev_flag};

  // Saturating event counters; a clear in the same cycle overrides an increment
  always_ff @(posedge Clk) begin
    for (int i = 0; i < N_CNT; i++) begin
      if (Rst || clr_cnt)
        cnt_q[i] <= '0;
      else if (inc[i] && !(&cnt_q[i]))
        cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end

  // Sticky error bits and interrupt mask
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sticky_q <= '0;
      mask_q   <= '0;
    end else begin
      if (ev_align)       sticky_q[STK_ALIGN] <= 1'b1;
      if (ev_runt)        sticky_q[STK_RUNT]  <= 1'b1;
      if (ev_frame_abort) sticky_q[STK_ABORT] <= 1'b1;
      if (clr_stk)        sticky_q <= '0;
      if (ld_mask)        mask_q   <= wr_data[4:2];
    end
  end

  assign irq_req = |(sticky_q & mask_q);

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_FLAGS:  rd_data = cnt_q[0];
      REG_ABORTS: rd_data = cnt_q[1];
      REG_GOOD:   rd_data = cnt_q[2];
      REG_ALIGN:  rd_data = cnt_q[3];
      REG_RUNT:   rd_data = cnt_q[4];
      REG_IDLE:   rd_data = cnt_q[5];
      REG_STATUS: rd_data = CNT_W'({sticky_q, state_q});
      REG_MASK:   rd_data = CNT_W'({mask_q, 2'b00});
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: rtl/hdlc_line_monitor.sv
// Multi-channel HDLC line monitor: per-channel monitors, register decode,
// registered read port and combined interrupt.
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 16,
  parameter int IDLE_LEN       = 15,
  parameter int MIN_FRAME_BITS = 32,
  parameter int BITCNT_W       = 12
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [N_CH-1:0]           LineIn,
  input  logic [N_CH-1:0]           LineVld,
  input  logic [$clog2(N_CH)+2:0]   Address,
  input  logic                      ReadEnable,
  input  logic                      WriteEnable,
  input  logic [CNT_W-1:0]          DataIn,
  output logic [CNT_W-1:0]          DataOut,
  output logic                      DataOutVld,
  output logic [N_CH-1:0]           FlagDetect,
  output logic [N_CH-1:0]           AbortDetect,
  output logic [N_CH-1:0]           FrameGood,
  output logic                      Irq
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]  ch_idx;
  logic [2:0]       reg_idx;
  logic [CNT_W-1:0] chan_rd [N_CH];
  logic [N_CH-1:0]  chan_irq;
  logic [CNT_W-1:0] rd_sel;
  logic             unused_data;

  assign reg_idx     = Address[2:0];
  assign unused_data = ^DataIn[CNT_W-1:5];

  if (N_CH > 1) begin : g_multi
    assign ch_idx = Address[$clog2(N_CH)+2:3];
  end else begin : g_single
    assign ch_idx = '0;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    hdlc_mon_chan #(
      .CNT_W          (CNT_W),
      .IDLE_LEN       (IDLE_LEN),
      .MIN_FRAME_BITS (MIN_FRAME_BITS),
      .BITCNT_W       (BITCNT_W)
    ) u_chan (
      .Clk         (Clk),
      .Rst         (Rst),
      .line_bit    (LineIn[c]),
      .line_vld    (LineVld[c]),
      .wr_en       (WriteEnable && (ch_idx == CH_W'(c))),
      .reg_idx     (reg_idx),
      .wr_data     (DataIn[4:0]),
      .rd_data     (chan_rd[c]),
      .flag_pulse  (FlagDetect[c]),
      .abort_pulse (AbortDetect[c]),
      .good_pulse  (FrameGood[c]),
      .irq_req     (chan_irq[c])
    );
  end

  // Channel select for reads; an index beyond N_CH-1 reads zero
  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < N_CH; c++)
      if (ch_idx == CH_W'(c)) rd_sel = chan_rd[c];
  end

  // Read data register and interrupt register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      DataOut    <= '0;
      DataOutVld <= 1'b0;
      Irq        <= 1'b0;
    end else begin
      DataOutVld <= ReadEnable;
      DataOut    <= ReadEnable ? rd_sel : '0;
      Irq        <= |chan_irq;
    end
  end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Directed bench for hdlc_line_monitor with a read-data scoreboard.
module tb_hdlc_line_monitor;

  logic        Clk;
  logic        Rst;
  logic [1:0]  LineIn, LineVld;
  logic [3:0]  Address;
  logic        ReadEnable, WriteEnable;
  logic [15:0] DataIn, DataOut;
  logic        DataOutVld;
  logic [1:0]  FlagDetect, AbortDetect, FrameGood;
  logic        Irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];
  int flag_seen  [2] = '{0, 0};
  int abort_seen [2] = '{0, 0};
  int good_seen  [2] = '{0, 0};

  hdlc_line_monitor dut (
    .Clk(Clk), .Rst(Rst), .LineIn(LineIn), .LineVld(LineVld),
    .Address(Address), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
    .DataIn(DataIn), .DataOut(DataOut), .DataOutVld(DataOutVld),
    .FlagDetect(FlagDetect), .AbortDetect(AbortDetect), .FrameGood(FrameGood),
    .Irq(Irq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output monitor: pulse tallies and scoreboard comparison of read data
  always @(negedge Clk) begin
    logic [15:0] e;
    string       t;
    for (int c = 0; c < 2; c++) begin
      if (FlagDetect[c] === 1'b1)  flag_seen[c]++;
      if (AbortDetect[c] === 1'b1) abort_seen[c]++;
      if (FrameGood[c] === 1'b1)   good_seen[c]++;
    end
    if (DataOutVld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL read_unexpected observed %0h expected none", DataOut);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (DataOut === e) else begin
          errors++;
          $error("FAIL %s observed %0h expected %0h", t, DataOut, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ad(input int ch, input int r);
    ad = {ch[0], r[2:0]};
  endfunction

  task automatic send_bit(input int ch, input logic b);
    LineIn[ch]  = b;
    LineVld[ch] = 1'b1;
    tick();
    LineVld[ch] = 1'b0;
  endtask

  // MSB first
  task automatic send_bits(input int ch, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(ch, v[i]);
  endtask

  task automatic send_flag(input int ch);
    send_bits(ch, 32'h7E, 8);
  endtask

  task automatic rd(input int ch, input int r, input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    Address    = ad(ch, r);
    ReadEnable = 1'b1;
    tick();
    ReadEnable = 1'b0;
  endtask

  task automatic wr(input int ch, input int r, input logic [15:0] d);
    Address     = ad(ch, r);
    DataIn      = d;
    WriteEnable = 1'b1;
    tick();
    WriteEnable = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; LineIn = '0; LineVld = '0; Address = '0;
    ReadEnable = 1'b0; WriteEnable = 1'b0; DataIn = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Reset state
    check("rst_flag", 32'(FlagDetect), 0);
    check("rst_abort", 32'(AbortDetect), 0);
    check("rst_good", 32'(FrameGood), 0);
    check("rst_irq", 32'(Irq), 0);
    check("rst_dout", 32'(DataOut), 0);
    check("rst_doutvld", 32'(DataOutVld), 0);
    rd(0, 6, 16'h0000, "rst_status0");
    rd(1, 7, 16'h0000, "rst_mask1");

    // Idle ones: abort at the 7th one, idle once at the 15th
    send_bits(0, 32'hFFFFF, 20);
    check("idle_no_flag", 32'(flag_seen[0]), 0);
    rd(0, 5, 16'd1, "idle_cnt");
    rd(0, 6, 16'h0000, "idle_state");
    rd(0, 1, 16'd1, "idle_abort_cnt");
    send_bits(0, 32'hFFFFF, 20);
    rd(0, 5, 16'd1, "idle_cnt_again");
    check("idle_abort_pulses", 32'(abort_seen[0]), 1);

    // Good 32-bit frame
    send_flag(0);
    check("flag_latency_hi", 32'(FlagDetect[0]), 1);
    tick();
    check("flag_latency_lo", 32'(FlagDetect[0]), 0);
    send_bits(0, 32'hA5A5_0F0F, 32);
    send_flag(0);
    rd(0, 0, 16'd2, "good_flags");
    rd(0, 2, 16'd1, "good_cnt");
    rd(0, 3, 16'd0, "good_align");
    rd(0, 4, 16'd0, "good_runt");
    rd(0, 6, 16'h0001, "good_state_open");
    check("good_pulses", 32'(good_seen[0]), 1);

    // Stuffed frame: 0x1F bytes each followed by a stuffed zero
    for (int i = 0; i < 4; i++) begin
      send_bits(0, 32'h1F, 8);
      send_bit(0, 1'b0);
    end
    send_flag(0);
    rd(0, 2, 16'd2, "stuffed_good_cnt");
    rd(0, 3, 16'd0, "stuffed_align");
    // Same data without stuffing runs into seven ones
    send_bits(0, 32'h1FF0, 16);
    rd(0, 1, 16'd2, "unstuffed_abort_cnt");
    rd(0, 6, 16'h0010, "unstuffed_status");

    wr(0, 6, 16'h0003);
    rd(0, 6, 16'h0000, "clear_status");
    rd(0, 0, 16'd0, "clear_flags");

    // 13-bit payload: alignment error, then irq via mask
    send_flag(0);
    send_bits(0, 32'h1555, 13);
    send_flag(0);
    rd(0, 3, 16'd1, "align_cnt");
    rd(0, 6, 16'h0005, "align_status");
    check("irq_unmasked", 32'(Irq), 0);
    wr(0, 7, 16'h0004);
    check("irq_before_latency", 32'(Irq), 0);
    tick();
    check("irq_masked_on", 32'(Irq), 1);
    rd(0, 7, 16'h0004, "mask_rb");
    wr(0, 6, 16'h0002);
    tick();
    check("irq_cleared", 32'(Irq), 0);
    rd(0, 6, 16'h0001, "sticky_cleared");
    rd(0, 3, 16'd1, "align_kept");

    // Runt, then abort inside a frame
    send_bits(0, 32'hA5A5, 16);
    send_flag(0);
    rd(0, 4, 16'd1, "runt_cnt");
    rd(0, 6, 16'h0009, "runt_status");
    check("irq_runt_masked", 32'(Irq), 0);
    send_bits(0, 32'hA5, 8);
    send_bits(0, 32'h7F, 8);
    rd(0, 1, 16'd1, "frame_abort_cnt");
    rd(0, 6, 16'h0018, "frame_abort_status");

    // Read in the same cycle as a flag increment returns the old count
    send_bits(0, 32'h3F, 7);
    exp_q.push_back(16'd3);
    tag_q.push_back("rd_same_cycle_flag");
    Address = ad(0, 0); ReadEnable = 1'b1;
    LineIn[0] = 1'b0; LineVld[0] = 1'b1;
    tick();
    ReadEnable = 1'b0; LineVld[0] = 1'b0;
    rd(0, 0, 16'd4, "flags_after");

    // Counter clear in the same cycle as a flag increment
    send_bits(0, 32'h3F, 7);
    Address = ad(0, 6); DataIn = 16'h0001; WriteEnable = 1'b1;
    LineIn[0] = 1'b0; LineVld[0] = 1'b1;
    tick();
    WriteEnable = 1'b0; LineVld[0] = 1'b0;
    rd(0, 0, 16'd0, "clear_wins");
    rd(0, 4, 16'd0, "clear_runt");
    // Read and write together: read sees the pre-write status
    exp_q.push_back(16'h0019);
    tag_q.push_back("rdwr_pre_write");
    Address = ad(0, 6); DataIn = 16'h0002; WriteEnable = 1'b1; ReadEnable = 1'b1;
    tick();
    WriteEnable = 1'b0; ReadEnable = 1'b0;
    rd(0, 6, 16'h0001, "rdwr_post_write");

    // Channel 1 independent good frame
    send_flag(1);
    send_bits(1, 32'h1234_5678, 32);
    send_flag(1);
    rd(1, 2, 16'd1, "ch1_good");
    rd(1, 0, 16'd2, "ch1_flags");
    rd(1, 1, 16'd0, "ch1_aborts");

    // Reset mid-frame
    send_bits(0, 32'hA5A5, 16);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    rd(0, 6, 16'h0000, "rst_mid_status");
    rd(0, 7, 16'h0000, "rst_mid_mask");
    rd(1, 0, 16'd0, "rst_mid_ch1_flags");
    rd(1, 2, 16'd0, "rst_mid_ch1_good");
    send_flag(0);
    rd(0, 0, 16'd1, "rst_mid_flag");
    rd(0, 2, 16'd0, "rst_mid_no_good");
    rd(0, 3, 16'd0, "rst_mid_no_align");

    // Pulse totals
    check("flag_pulses_ch0", 32'(flag_seen[0]), 9);
    check("flag_pulses_ch1", 32'(flag_seen[1]), 2);
    check("abort_pulses_ch0", 32'(abort_seen[0]), 3);
    check("good_pulses_ch0", 32'(good_seen[0]), 2);
    check("good_pulses_ch1", 32'(good_seen[1]), 1);

    repeat (3) tick();
    check("read_queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
